// File: rtl/dds_pkg.sv
// Shared types for the DDS frequency-sweep sequencer: widths, FSM states, latched sweep config.
// Pure declarations; no latency, no backpressure.
package dds_pkg;

    localparam int KW_W_DEF    = 32;
    localparam int DWELL_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DWELL,
        ST_STEP,
        ST_DONE
    } sweep_state_e;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } sweep_dir_e;

    typedef struct packed {
        logic [KW_W_DEF-1:0]    start_kw;
        logic [KW_W_DEF-1:0]    stop_kw;
        logic [KW_W_DEF-1:0]    step_kw;
        logic [DWELL_W_DEF-1:0] dwell;
        logic                   continuous;
        sweep_dir_e             dir;
    } sweep_cfg_t;

    // A dwell of 0 behaves like 1; the counter counts down to zero inclusive.
    function automatic logic [DWELL_W_DEF-1:0] dwell_reload(input logic [DWELL_W_DEF-1:0] d);
        return (d == '0) ? '0 : d - DWELL_W_DEF'(1);
    endfunction

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Control/config and DDS-facing outputs of the sweep sequencer, bundled for one-port hookup.
// Wires only; no latency, no backpressure.
interface dds_sweep_ctrl_if #(
    parameter int KW_W    = 32,
    parameter int DWELL_W = 16
);
    logic               start;
    logic               abort;
    logic               continuous;
    logic [KW_W-1:0]    start_kw;
    logic [KW_W-1:0]    stop_kw;
    logic [KW_W-1:0]    step_kw;
    logic [DWELL_W-1:0] dwell;
    logic [KW_W-1:0]    kw;
    logic               phase_clr;
    logic               busy;
    logic               done;
    logic [KW_W-1:0]    point_idx;

    modport master (
        output start, abort, continuous, start_kw, stop_kw, step_kw, dwell,
        input  kw, phase_clr, busy, done, point_idx
    );

    modport slave (
        input  start, abort, continuous, start_kw, stop_kw, step_kw, dwell,
        output kw, phase_clr, busy, done, point_idx
    );
endinterface

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter with zero flag that times how long each sweep point is held.
// Load/decrement take effect on the next clk edge; no backpressure (decrement stalls at zero).
module dds_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Steps the DDS tuning word from start_kw to stop_kw with clamping, dwell timing, repeat and abort.
// All outputs registered, first point one cycle after start; no backpressure (abort wins over all).
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int KW_W    = KW_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    dds_sweep_ctrl_if.slave  sw
);

    sweep_state_e      state_q, state_d;
    sweep_cfg_t        cfg_q, cfg_d;
    logic [KW_W-1:0]   kw_q, kw_d;
    logic [KW_W-1:0]   idx_q, idx_d;
    logic              phase_clr_q, phase_clr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_zero;
    logic [DWELL_W-1:0] tmr_val;

    logic [KW_W:0]     sum;
    logic [KW_W:0]     diff;
    logic [KW_W-1:0]   kw_next;
    logic              last_point;

    dds_dwell_timer #(.W(DWELL_W)) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // The extra top bit carries (ascending) or borrows (descending) on wrap past the word range.
    assign sum  = {1'b0, kw_q} + {1'b0, cfg_q.step_kw};
    assign diff = {1'b0, kw_q} - {1'b0, cfg_q.step_kw};

    always_comb begin
        kw_next = '0;
        if (cfg_q.dir == DIR_UP) begin
            kw_next = (sum[KW_W] || (sum[KW_W-1:0] > cfg_q.stop_kw)) ? cfg_q.stop_kw : sum[KW_W-1:0];
        end else begin
            kw_next = (diff[KW_W] || (diff[KW_W-1:0] < cfg_q.stop_kw)) ? cfg_q.stop_kw : diff[KW_W-1:0];
        end
    end

    assign last_point = (kw_q == cfg_q.stop_kw) || (cfg_q.step_kw == '0);

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        kw_d        = kw_q;
        idx_d       = idx_q;
        phase_clr_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        tmr_val     = dwell_reload(cfg_q.dwell);

        unique case (state_q)
            ST_IDLE: begin
                if (sw.start) begin
                    cfg_d.start_kw   = sw.start_kw;
                    cfg_d.stop_kw    = sw.stop_kw;
                    cfg_d.step_kw    = sw.step_kw;
                    cfg_d.dwell      = sw.dwell;
                    cfg_d.continuous = sw.continuous;
                    cfg_d.dir        = (sw.start_kw <= sw.stop_kw) ? DIR_UP : DIR_DOWN;
                    kw_d             = sw.start_kw;
                    idx_d            = '0;
                    phase_clr_d      = 1'b1;
                    busy_d           = 1'b1;
                    tmr_load         = 1'b1;
                    tmr_val          = dwell_reload(sw.dwell);
                    state_d          = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (!last_point) begin
                    state_d = ST_STEP;
                end else if (cfg_q.continuous) begin
                    kw_d        = cfg_q.start_kw;
                    idx_d       = '0;
                    phase_clr_d = 1'b1;
                    tmr_load    = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_STEP: begin
                kw_d     = kw_next;
                idx_d    = idx_q + KW_W'(1);
                tmr_load = 1'b1;
                state_d  = ST_DWELL;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (sw.abort) begin
            state_d     = ST_IDLE;
            cfg_d       = cfg_q;
            kw_d        = '0;
            idx_d       = '0;
            phase_clr_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            tmr_load    = 1'b1;
            tmr_val     = '0;
            tmr_dec     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            kw_q        <= '0;
            idx_q       <= '0;
            phase_clr_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            kw_q        <= kw_d;
            idx_q       <= idx_d;
            phase_clr_q <= phase_clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sw.kw        = kw_q;
    assign sw.point_idx = idx_q;
    assign sw.phase_clr = phase_clr_q;
    assign sw.busy      = busy_q;
    assign sw.done      = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Randomized and directed sweeps checked cycle-by-cycle against a point-list reference model.
module tb_dds_sweep_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dds_sweep_ctrl_if #(.KW_W(32), .DWELL_W(16)) sw ();

    dds_sweep_ctrl #(.KW_W(32), .DWELL_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] kw;
        logic        pc;
        logic        busy;
        logic        done;
        logic [31:0] idx;
    } obs_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sweep_no = 0;
    logic [31:0] pts[$];
    obs_t        exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (sweep %0d): got 0x%0h expected 0x%0h", tag, sweep_no, got, exp);
        end
    endtask

    task automatic check_obs(input string where, input obs_t e);
        check({where, " kw"},        sw.kw,               e.kw);
        check({where, " phase_clr"}, 32'(sw.phase_clr),   32'(e.pc));
        check({where, " busy"},      32'(sw.busy),        32'(e.busy));
        check({where, " done"},      32'(sw.done),        32'(e.done));
        check({where, " point_idx"}, sw.point_idx,        e.idx);
    endtask

    // Reference: the list of tuning words visited by one pass, with clamping at stop.
    task automatic build_points(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st);
        longint p, nx;
        pts.delete();
        p = longint'(s);
        pts.push_back(s);
        while ((p != longint'(e)) && (st != 0)) begin
            if (s <= e) begin
                nx = p + longint'(st);
                if (nx > longint'(e)) nx = longint'(e);
            end else begin
                nx = p - longint'(st);
                if (nx < longint'(e)) nx = longint'(e);
            end
            p = nx;
            pts.push_back(32'(p));
        end
    endtask

    task automatic drive_noise_cfg();
        sw.start_kw   = $urandom;
        sw.stop_kw    = $urandom;
        sw.step_kw    = $urandom;
        sw.dwell      = 16'($urandom);
        sw.continuous = 1'($urandom);
    endtask

    // abort_at: -1 none, -2 random (single-shot), else entry index after which abort is raised.
    task automatic sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                         input logic [15:0] d, input bit cont, input int abort_in, input bit noise);
        int   dd, abort_at, hold;
        obs_t o;
        sweep_no++;
        abort_at = abort_in;
        build_points(s, e, st);
        exp_q.delete();
        dd = (d == 0) ? 1 : int'(d);
        do begin
            for (int i = 0; i < pts.size(); i++) begin
                hold = dd + ((i < pts.size() - 1) ? 1 : 0);
                for (int c = 0; c < hold; c++) begin
                    o.kw = pts[i]; o.pc = (i == 0 && c == 0); o.busy = 1'b1;
                    o.done = 1'b0; o.idx = 32'(i);
                    exp_q.push_back(o);
                end
            end
        end while (cont && (exp_q.size() <= abort_at) && (exp_q.size() < 4000));
        if (!cont) begin
            o.kw = pts[pts.size()-1]; o.pc = 1'b0; o.busy = 1'b0; o.done = 1'b1;
            o.idx = 32'(pts.size() - 1);
            exp_q.push_back(o);
            o.done = 1'b0;
            exp_q.push_back(o);
            exp_q.push_back(o);
        end
        if (abort_at == -2) abort_at = $urandom_range(0, exp_q.size() - 1);
        if (abort_at >= 0 && abort_at < exp_q.size()) begin
            while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
            o.kw = '0; o.pc = 1'b0; o.busy = 1'b0; o.done = 1'b0; o.idx = '0;
            exp_q.push_back(o);
            exp_q.push_back(o);
        end else begin
            abort_at = -1;
        end

        @(negedge clk);
        sw.start = 1'b1; sw.abort = 1'b0;
        sw.start_kw = s; sw.stop_kw = e; sw.step_kw = st; sw.dwell = d; sw.continuous = cont;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            sw.start = 1'b0;
            sw.abort = 1'b0;
            drive_noise_cfg();
            check_obs($sformatf("cyc%0d", k), exp_q[k]);
            if (k == abort_at) begin
                sw.abort = 1'b1;
                sw.start = 1'($urandom);
            end else if (noise && (exp_q[k].busy || exp_q[k].done) && ($urandom_range(0, 3) == 0)) begin
                sw.start = 1'b1;
            end
        end
        @(negedge clk);
        sw.start = 1'b0;
        sw.abort = 1'b0;
    endtask

    initial begin
        logic [31:0] s, e, st;
        int          mode;
        bit          cont;

        sw.start = 1'b0; sw.abort = 1'b0; sw.continuous = 1'b0;
        sw.start_kw = '0; sw.stop_kw = '0; sw.step_kw = '0; sw.dwell = '0;
        #1;
        check("reset kw",        sw.kw,             32'd0);
        check("reset busy",      32'(sw.busy),      32'd0);
        check("reset done",      32'(sw.done),      32'd0);
        check("reset phase_clr", 32'(sw.phase_clr), 32'd0);
        check("reset point_idx", sw.point_idx,      32'd0);
        @(negedge clk);
        rst = 1'b0;

        sweep(32'd100, 32'd130, 32'd10, 16'd3, 1'b0, -1, 1'b1);
        sweep(32'd130, 32'd100, 32'd12, 16'd1, 1'b0, -1, 1'b0);
        sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd2, 1'b0, -1, 1'b0);
        sweep(32'd0, 32'd20, 32'd10, 16'd2, 1'b1, 20, 1'b1);
        sweep(32'd55, 32'd90, 32'd0, 16'd0, 1'b0, -1, 1'b1);
        sweep(32'd77, 32'd77, 32'd5, 16'd2, 1'b1, 9, 1'b0);
        sweep(32'd20, 32'd0, 32'd30, 16'd1, 1'b0, -1, 1'b0);
        sweep(32'd100, 32'd130, 32'd10, 16'd3, 1'b0, 5, 1'b0);

        // Asynchronous reset landing between edges in the middle of a dwell.
        sweep_no++;
        @(negedge clk);
        sw.start = 1'b1; sw.start_kw = 32'd500; sw.stop_kw = 32'd600;
        sw.step_kw = 32'd25; sw.dwell = 16'd6; sw.continuous = 1'b0;
        @(negedge clk);
        sw.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-rst kw", sw.kw, 32'd500);
        #2;
        rst = 1'b1;
        #1;
        check("async rst kw",        sw.kw,             32'd0);
        check("async rst busy",      32'(sw.busy),      32'd0);
        check("async rst done",      32'(sw.done),      32'd0);
        check("async rst phase_clr", 32'(sw.phase_clr), 32'd0);
        check("async rst point_idx", sw.point_idx,      32'd0);
        @(negedge clk);
        rst = 1'b0;
        sweep(32'd10, 32'd40, 32'd15, 16'd2, 1'b0, -1, 1'b1);

        for (int t = 0; t < 30; t++) begin
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                s  = 32'hFFFF_FF00 + $urandom_range(0, 255);
                e  = 32'hFFFF_FF00 + $urandom_range(0, 255);
                st = $urandom_range(0, 300);
            end else begin
                s  = $urandom_range(0, 100);
                e  = $urandom_range(0, 100);
                st = $urandom_range(0, 30);
            end
            cont = ($urandom_range(0, 3) == 0);
            if (cont)
                sweep(s, e, st, 16'($urandom_range(0, 4)), 1'b1, $urandom_range(3, 150), 1'b1);
            else
                sweep(s, e, st, 16'($urandom_range(0, 4)), 1'b0,
                      ($urandom_range(0, 3) == 0) ? -2 : -1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep sequencer that drives the 32-bit tuning word KW of the DDS phase-accumulator/sine-ROM core. It steps KW from a start word to a stop word in fixed increments, holding each point for a programmable dwell. It supports single-shot and continuous (repeat) modes, ascending or descending sweeps, and abort. It sits between the control/register logic and the DDS core, and also emits a phase-clear strobe so each sweep starts at a known phase.

Parameters:
KW_W, 32, tuning-word width (matches DDS KW port)
DWELL_W, 16, width of dwell counter (cycles per sweep point)

Ports:
clk  in  1  system clock, same clock as DDS core
rst  in  1  asynchronous, active-high reset
start  in  1  1-cycle request to begin a sweep; honoured only in IDLE
abort  in  1  terminate sweep; wins over every other event
continuous  in  1  sampled at start: 1 = restart from start_kw after each completed sweep
start_kw  in  KW_W  first tuning word, sampled at start
stop_kw  in  KW_W  last tuning word, sampled at start
step_kw  in  KW_W  unsigned increment magnitude, sampled at start
dwell  in  DWELL_W  cycles per point, sampled at start; 0 treated as 1
kw  out  KW_W  tuning word to DDS
phase_clr  out  1  1-cycle pulse aligned with the first kw of every sweep pass
busy  out  1  high from first point until DONE/IDLE
done  out  1  1-cycle pulse after last point's dwell (single-shot mode only)
point_idx  out  KW_W  index of current point within pass, 0-based

Behaviour:
- Reset (async assert, sync release): state IDLE; kw=0, phase_clr=0, busy=0, done=0, point_idx=0; config registers cleared.
- Direction is fixed at start: ascending if start_kw <= stop_kw, otherwise descending. All arithmetic is unsigned KW_W+1 bits; the carry/borrow bit detects overshoot.
- FSM states: IDLE, DWELL, STEP, DONE.
- IDLE: start=1 at cycle n latches the config. At n+1: kw=start_kw, phase_clr=1, busy=1, point_idx=0, dwell counter loaded to max(dwell,1)-1, state DWELL.
- DWELL: counter decrements each cycle. At 0: go to STEP if kw != stop_kw and step_kw != 0; otherwise end the pass. Each point is held exactly max(dwell,1) cycles, plus 1 STEP cycle where kw is unchanged.
- STEP (1 cycle): next = kw ± step_kw. If the result passes stop_kw, or carries/borrows out of KW_W bits, kw is clamped to stop_kw. point_idx increments; counter is reloaded; state returns to DWELL.
- End of pass, single-shot: state DONE for 1 cycle with done=1 and busy=0, kw holds stop_kw, then IDLE.
- End of pass, continuous: kw=start_kw and phase_clr=1 on the next cycle; point_idx=0; stays busy; done is not pulsed.
- step_kw=0 or start_kw=stop_kw: a single point held for the dwell, then end of pass as above. Continuous mode then repeats indefinitely with phase_clr every pass.
- abort=1 in any state: on the next cycle state is IDLE, kw=0, busy=0, point_idx=0, no done pulse. abort with start in the same cycle: abort wins and start is ignored.
- start while not IDLE is ignored. Config inputs are ignored except at the accepted start.
- kw is registered and glitch-free; it changes only on the cycles defined above.
- Reset mid-sweep: outputs return to reset values immediately; no done pulse.

Decomposition:
- Shared package dds_pkg: KW_W default, sweep state enum (IDLE/DWELL/STEP/DONE), and a config struct {start_kw, stop_kw, step_kw, dwell, continuous, dir}.
- One natural sub-module, dds_dwell_timer: loadable down-counter with zero flag. FSM and clamp arithmetic stay in dds_sweep_ctrl.

Test Plan:
- start_kw=100, stop_kw=130, step=10, dwell=3, single-shot -> kw sequence 100,110,120,130, each point 3 cycles plus 1 STEP cycle; phase_clr at the first 100; done 1 cycle after 130's dwell; busy low with done.
- start_kw=130, stop_kw=100, step=12, dwell=1 -> kw 130,118,106,100 (clamped); point_idx 0..3; single done pulse.
- start_kw=0xFFFF_FFF0, stop_kw=0xFFFF_FFFF, step=0x20 -> carry out clamps to 0xFFFF_FFFF after the first point; two points total.
- continuous=1, 0->20 step 10, dwell=2 -> kw repeats 0,10,20,0,...; phase_clr at every 0; done never asserted; abort mid-point -> next cycle kw=0, busy=0, no done.
- step=0 and dwell=0 -> one point for 1 cycle, then done. start while busy and start+abort in the same cycle -> both ignored/aborted as specified.
- Async rst asserted mid-DWELL between clock edges -> all outputs are zero before the next clk edge; the sweep restarts cleanly on the next start.
